// File: rtl/pc_redirect_unit.sv
// ============================================================================
// Module      : pc_redirect_unit
// Description : IF-stage fetch PC sequencer. It accepts EX redirect targets
//               and issues pipeline flushes.
//               The optional macro BRANCH_DELAY_SLOT_EN keeps the ID-stage
//               instruction alive across a redirect.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_redirect_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_target_i,
    output logic        redirect_ready_o,
    output logic [31:0] pc_o,
    output logic [31:0] incr_pc_o,
    output logic        fetch_valid_o,
    output logic        flush_if_o,
    output logic        flush_id_o,
    output logic        misalign_o,
    output logic [31:0] badaddr_o
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

`ifdef BRANCH_DELAY_SLOT_EN
    localparam logic C_FLUSH_ID = 1'b0;
`else
    localparam logic C_FLUSH_ID = 1'b1;
`endif

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] badaddr_q, badaddr_d;
    logic        misalign_d;
    logic        ready_q;
    logic        fetch_valid_q;
    logic        flush_if_q;
    logic        flush_id_q;
    logic        misalign_q;

    logic        w_accept;
    logic        w_misaligned;
    logic [31:0] w_incr_pc;

    assign w_incr_pc    = pc_q + 32'd4;
    assign w_accept     = redirect_valid_i & ready_q;
    assign w_misaligned = (redirect_target_i[1:0] != 2'b00);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        badaddr_d  = badaddr_q;
        misalign_d = 1'b0;
        case (state_q)
            ST_RUN, ST_HOLD: begin
                // Redirect wins over stall: the branch is older than the stalled instruction.
                if (w_accept) begin
                    state_d = ST_FLUSH;
                    if (w_misaligned) begin
                        pc_d       = EXC_VECTOR;
                        badaddr_d  = redirect_target_i;
                        misalign_d = 1'b1;
                    end else begin
                        pc_d = redirect_target_i;
                    end
                end else if (stall_i) begin
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_RUN;
                    pc_d    = w_incr_pc;
                end
            end
            ST_FLUSH: begin
                state_d = stall_i ? ST_HOLD : ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Outputs are registered decodes of the next state, so they change only on clock edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            pc_q          <= RESET_PC;
            badaddr_q     <= 32'h0;
            ready_q       <= 1'b1;
            fetch_valid_q <= 1'b1;
            flush_if_q    <= 1'b0;
            flush_id_q    <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            badaddr_q     <= badaddr_d;
            ready_q       <= (state_d != ST_FLUSH);
            fetch_valid_q <= (state_d != ST_FLUSH);
            flush_if_q    <= (state_d == ST_FLUSH);
            flush_id_q    <= (state_d == ST_FLUSH) & C_FLUSH_ID;
            misalign_q    <= misalign_d;
        end
    end

    assign redirect_ready_o = ready_q;
    assign pc_o             = pc_q;
    assign incr_pc_o        = w_incr_pc;
    assign fetch_valid_o    = fetch_valid_q;
    assign flush_if_o       = flush_if_q;
    assign flush_id_o       = flush_id_q;
    assign misalign_o       = misalign_q;
    assign badaddr_o        = badaddr_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_redirect_unit.sv
// ============================================================================
// Module      : tb_pc_redirect_unit
// Description : Scoreboard bench for pc_redirect_unit with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_redirect_unit;

`ifdef BRANCH_DELAY_SLOT_EN
    localparam logic C_EXP_FID = 1'b0;
`else
    localparam logic C_EXP_FID = 1'b1;
`endif

    logic        clk;
    logic        rst_n;
    logic        stall_i;
    logic        redirect_valid_i;
    logic [31:0] redirect_target_i;
    logic        redirect_ready_o;
    logic [31:0] pc_o;
    logic [31:0] incr_pc_o;
    logic        fetch_valid_o;
    logic        flush_if_o;
    logic        flush_id_o;
    logic        misalign_o;
    logic [31:0] badaddr_o;

    typedef struct packed {
        logic [31:0] pc;
        logic        fv;
        logic        rdy;
        logic        fif;
        logic        fid;
        logic        mis;
        logic [31:0] bad;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   vec_idx = 0;

    pc_redirect_unit #(
        .RESET_PC   (32'h0000_0000),
        .EXC_VECTOR (32'h0000_0080)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .stall_i           (stall_i),
        .redirect_valid_i  (redirect_valid_i),
        .redirect_target_i (redirect_target_i),
        .redirect_ready_o  (redirect_ready_o),
        .pc_o              (pc_o),
        .incr_pc_o         (incr_pc_o),
        .fetch_valid_o     (fetch_valid_o),
        .flush_if_o        (flush_if_o),
        .flush_id_o        (flush_id_o),
        .misalign_o        (misalign_o),
        .badaddr_o         (badaddr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string name, input int idx,
                                  input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s [vec %0d]: got %h expected %h", name, idx, act, exp);
        end
    endfunction

    function automatic void check_all(input int idx, input exp_t e);
        check("pc",          idx, pc_o,                      e.pc);
        check("incr_pc",     idx, incr_pc_o,                 e.pc + 32'd4);
        check("fetch_valid", idx, {31'h0, fetch_valid_o},    {31'h0, e.fv});
        check("ready",       idx, {31'h0, redirect_ready_o}, {31'h0, e.rdy});
        check("flush_if",    idx, {31'h0, flush_if_o},       {31'h0, e.fif});
        check("flush_id",    idx, {31'h0, flush_id_o},       {31'h0, e.fid});
        check("misalign",    idx, {31'h0, misalign_o},       {31'h0, e.mis});
        check("badaddr",     idx, badaddr_o,                 e.bad);
    endfunction

    // Monitor: every cycle the DUT presents a new fetch state; compare it against the oldest expectation.
    initial begin
        int mon_idx;
        mon_idx = 0;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                check_all(mon_idx, exp_q.pop_front());
                mon_idx++;
            end
        end
    end

    // Called at a negedge: drive inputs, queue the outputs expected after the next posedge.
    task automatic cyc(input logic st, input logic rv, input logic [31:0] tgt,
                       input logic [31:0] pc, input logic flush, input logic mis,
                       input logic [31:0] bad);
        exp_t e;
        stall_i           = st;
        redirect_valid_i  = rv;
        redirect_target_i = tgt;
        e.pc  = pc;
        e.fv  = ~flush;
        e.rdy = ~flush;
        e.fif = flush;
        e.fid = flush & C_EXP_FID;
        e.mis = mis;
        e.bad = bad;
        exp_q.push_back(e);
        vec_idx++;
        @(negedge clk);
    endtask

    initial begin
        exp_t rst_e;
        rst_n             = 1'b0;
        stall_i           = 1'b0;
        redirect_valid_i  = 1'b0;
        redirect_target_i = 32'h0;
        #12;
        rst_e = '{pc: 32'h0, fv: 1'b1, rdy: 1'b1, fif: 1'b0, fid: 1'b0, mis: 1'b0, bad: 32'h0};
        check_all(-1, rst_e);

        @(negedge clk);
        rst_n = 1'b1;
        // sequential fetch from RESET_PC
        cyc(0, 0, 32'h0,   32'h0000_0004, 0, 0, 32'h0);
        cyc(0, 0, 32'h0,   32'h0000_0008, 0, 0, 32'h0);
        cyc(0, 0, 32'h0,   32'h0000_000C, 0, 0, 32'h0);
        cyc(0, 0, 32'h0,   32'h0000_0010, 0, 0, 32'h0);
        // three-cycle stall at 0x10
        cyc(1, 0, 32'h0,   32'h0000_0010, 0, 0, 32'h0);
        cyc(1, 0, 32'h0,   32'h0000_0010, 0, 0, 32'h0);
        cyc(1, 0, 32'h0,   32'h0000_0010, 0, 0, 32'h0);
        cyc(0, 0, 32'h0,   32'h0000_0014, 0, 0, 32'h0);
        cyc(0, 0, 32'h0,   32'h0000_0018, 0, 0, 32'h0);
        // aligned redirect to 0x40
        cyc(0, 1, 32'h40,  32'h0000_0040, 1, 0, 32'h0);
        cyc(0, 0, 32'h0,   32'h0000_0040, 0, 0, 32'h0);
        cyc(0, 0, 32'h0,   32'h0000_0044, 0, 0, 32'h0);
        // redirect with stall, second redirect waits out FLUSH
        cyc(1, 1, 32'h100, 32'h0000_0100, 1, 0, 32'h0);
        cyc(1, 1, 32'h200, 32'h0000_0100, 0, 0, 32'h0);
        cyc(0, 1, 32'h200, 32'h0000_0200, 1, 0, 32'h0);
        cyc(0, 0, 32'h0,   32'h0000_0200, 0, 0, 32'h0);
        // misaligned target goes to the exception vector
        cyc(0, 1, 32'h42,  32'h0000_0080, 1, 1, 32'h42);
        cyc(0, 0, 32'h0,   32'h0000_0080, 0, 0, 32'h42);
        cyc(0, 0, 32'h0,   32'h0000_0084, 0, 0, 32'h42);
        // top-of-memory wrap
        cyc(0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 0, 32'h42);
        cyc(0, 0, 32'h0,   32'hFFFF_FFFC, 0, 0, 32'h42);
        cyc(0, 0, 32'h0,   32'h0000_0000, 0, 0, 32'h42);
        // second misalign updates badaddr
        cyc(0, 1, 32'h103, 32'h0000_0080, 1, 1, 32'h103);
        cyc(0, 0, 32'h0,   32'h0000_0080, 0, 0, 32'h103);
        // enter FLUSH, then reset asynchronously mid-cycle
        cyc(0, 1, 32'h300, 32'h0000_0300, 1, 0, 32'h103);
        #1;
        rst_n            = 1'b0;
        redirect_valid_i = 1'b0;
        #1;
        check_all(-2, rst_e);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(0, 0, 32'h0,   32'h0000_0004, 0, 0, 32'h0);
        cyc(0, 0, 32'h0,   32'h0000_0008, 0, 0, 32'h0);

        repeat (2) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
